run_monitor: RTL and testbench
==============================

RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of 32-bit watched channels.
REQ-002 SHALL have parameter CNT_W, default 32: cycle counter width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 800000: RUN cycles before timeout.
REQ-004 SHALL have parameter DONE_VALUE, default 32'h0000_0001: pass code.
REQ-005 SHALL have parameter FAIL_VALUE, default 32'hBAD0_0BAD: fail code.
REQ-006 SHALL have parameter STABLE_CYCLES, default 1 (minimum 1): consecutive pass-code matches required.
REQ-007 SHALL have parameter PROGRESS_LOG2, default 15: progress interval is 2^PROGRESS_LOG2 counted cycles.
REQ-008 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-009 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-010 SHALL have port enable_i, input, 1: start from IDLE; pause counting when low in RUN.
REQ-011 SHALL have port done_word_i, input, 32: status word compared against pass and fail codes.
REQ-012 SHALL have port chan_i, input, CHANNELS*32: watched values, channel k in bits [32k+31:32k].
REQ-013 SHALL have port state_o, input-independent output, 3: IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4.
REQ-014 SHALL have port finish_o, output, 1: one-cycle pulse on terminal-state entry.
REQ-015 SHALL have port cycle_count_o, output, CNT_W: live RUN cycle count.
REQ-016 SHALL have port final_count_o, output, CNT_W: count captured at terminal entry.
REQ-017 SHALL have port snap_o, output, CHANNELS*32: chan_i captured at terminal entry or progress tick.
REQ-018 SHALL have port progress_o, output, 1: one-cycle progress pulse.

Function
REQ-019 IDLE->RUN SHALL occur on an edge with enable_i=1; cycle_count stays 0 on that edge; codes are not evaluated in IDLE.
REQ-020 In RUN, cycle_count SHALL increment by 1 on each edge with enable_i=1, hold when enable_i=0, and saturate at all-ones.
REQ-021 A match counter SHALL increment on each RUN edge with done_word_i==DONE_VALUE (regardless of enable_i) and clear on mismatch; RUN->PASS on the edge completing STABLE_CYCLES consecutive matches (STABLE_CYCLES=1: first matching edge).
REQ-022 RUN->FAIL SHALL occur on the first RUN edge with done_word_i==FAIL_VALUE.
REQ-023 RUN->TIMEOUT SHALL occur on an edge where registered cycle_count==TIMEOUT_CYCLES and neither PASS nor FAIL fires.
REQ-024 Priority on the same edge SHALL be FAIL > PASS > TIMEOUT.
REQ-025 On terminal entry, final_count_o SHALL capture registered cycle_count and snap_o SHALL capture chan_i on that same edge.
REQ-026 finish_o SHALL be high for exactly the one cycle following terminal entry.
REQ-027 Terminal states SHALL hold, with all outputs frozen and finish_o low, until rst_i.

Reset
REQ-028 On a clock edge with rst_i=1, state SHALL become IDLE and cycle_count, match counter, final_count_o, snap_o, finish_o and progress_o SHALL all become 0, including mid-RUN or in a terminal state.
REQ-029 rst_i SHALL override every other event on the same edge.

Configuration
REQ-030 With RUN_MONITOR_PROGRESS_EN defined, progress_o SHALL pulse for one cycle after any RUN edge on which cycle_count increments to a nonzero value whose low PROGRESS_LOG2 bits are 0, and snap_o SHALL capture chan_i on that edge.
REQ-031 Without RUN_MONITOR_PROGRESS_EN, progress_o SHALL be constant 0, snap_o SHALL update only on terminal entry, and no progress logic SHALL be synthesised.

Verification (TIMEOUT_CYCLES=100, STABLE_CYCLES=3, PROGRESS_LOG2=4, CHANNELS=2)
REQ-032 enable_i=1, then done_word_i=1 for 3 edges starting at count 20, chan_i={32'h5,32'hA} -> state_o=PASS, final_count_o=22, snap_o={5,A}, finish_o pulses once.
REQ-033 done_word_i=1, 1, 0, 1, 1, 1 -> PASS only on the sixth edge; match counter clears on the zero.
REQ-034 done_word_i never matches -> TIMEOUT with final_count_o=100; with macro, progress_o pulses at counts 16, 32, ..., 96 (6 pulses).
REQ-035 done_word_i=FAIL_VALUE on the edge where cycle_count==100 and the third pass match would complete -> FAIL wins, final_count_o=100.
REQ-036 enable_i low for 10 edges mid-RUN -> cycle_count holds; TIMEOUT delayed by 10 cycles.
REQ-037 rst_i=1 for one edge in PASS or mid-RUN -> all outputs 0, state_o=IDLE; a new run restarts from count 0.

Source files
------------

// File: rtl/run_monitor.sv
// run_monitor: watches a run for pass/fail codes or timeout, counting RUN cycles and snapshotting channels.
// Define RUN_MONITOR_PROGRESS_EN to add periodic progress pulses with channel snapshots.
module run_monitor #(
  parameter int          CHANNELS       = 4,
  parameter int          CNT_W          = 32,
  parameter int          TIMEOUT_CYCLES = 800000,
  parameter logic [31:0] DONE_VALUE     = 32'h0000_0001,
  parameter logic [31:0] FAIL_VALUE     = 32'hBAD0_0BAD,
  parameter int          STABLE_CYCLES  = 1,
  parameter int          PROGRESS_LOG2  = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [31:0]           done_word_i,
  input  logic [CHANNELS*32-1:0] chan_i,
  output logic [2:0]            state_o,
  output logic                  finish_o,
  output logic [CNT_W-1:0]      cycle_count_o,
  output logic [CNT_W-1:0]      final_count_o,
  output logic [CHANNELS*32-1:0] snap_o,
  output logic                  progress_o
);
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;
  localparam int MW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d, final_q;
  logic [MW-1:0]           match_q;
  logic [CHANNELS*32-1:0]  snap_q;
  logic                    finish_q, is_done, is_fail, is_pass, is_tmo;
  assign cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign is_done = done_word_i == DONE_VALUE;
  assign is_fail = done_word_i == FAIL_VALUE;
  assign is_pass = is_done && match_q == MW'(STABLE_CYCLES - 1);
  assign is_tmo  = cnt_q == CNT_W'(TIMEOUT_CYCLES);
`ifdef RUN_MONITOR_PROGRESS_EN
  localparam logic [CNT_W-1:0] PMASK = (CNT_W'(1) << PROGRESS_LOG2) - 1'b1;
  logic prog_q;
  assign progress_o = prog_q;
`else
  assign progress_o = PROGRESS_LOG2 < 0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      match_q  <= '0;
      final_q  <= '0;
      snap_q   <= '0;
      finish_q <= 1'b0;
`ifdef RUN_MONITOR_PROGRESS_EN
      prog_q   <= 1'b0;
`endif
    end else begin
      finish_q <= 1'b0;
`ifdef RUN_MONITOR_PROGRESS_EN
      prog_q   <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: if (enable_i) state_q <= ST_RUN;
        ST_RUN: begin
          if (is_fail || is_pass || is_tmo) begin
            state_q  <= is_fail ? ST_FAIL : is_pass ? ST_PASS : ST_TIMEOUT;
            final_q  <= cnt_q;
            snap_q   <= chan_i;
            finish_q <= 1'b1;
          end else begin
            match_q <= is_done ? match_q + 1'b1 : '0;
            if (enable_i) cnt_q <= cnt_d;
`ifdef RUN_MONITOR_PROGRESS_EN
            // a tick only counts when the counter actually moves, so saturation never re-fires it
            if (enable_i && !(&cnt_q) && cnt_d != '0 && (cnt_d & PMASK) == '0) begin
              prog_q <= 1'b1;
              snap_q <= chan_i;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end
  assign state_o       = state_q;
  assign finish_o      = finish_q;
  assign cycle_count_o = cnt_q;
  assign final_count_o = final_q;
  assign snap_o        = snap_q;
endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: table-driven runs with a finish scoreboard, plus reset sequences.
module tb_run_monitor;
  localparam logic [31:0] DV = 32'h0000_0001;
  localparam logic [31:0] FV = 32'hBAD0_0BAD;
  logic        clk = 1'b0, rst, en, fin, prog;
  logic [31:0] dw, cc, fc;
  logic [63:0] chan, snap;
  logic [2:0]  st;
  always #5 clk = ~clk;
  run_monitor #(
    .CHANNELS(2), .CNT_W(32), .TIMEOUT_CYCLES(100), .DONE_VALUE(DV),
    .FAIL_VALUE(FV), .STABLE_CYCLES(3), .PROGRESS_LOG2(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .done_word_i(dw), .chan_i(chan),
    .state_o(st), .finish_o(fin), .cycle_count_o(cc), .final_count_o(fc),
    .snap_o(snap), .progress_o(prog)
  );
  typedef struct {
    int              pat_at;
    int              pat_len;
    logic [5:0][31:0] pat;
    int              pause_at;
    int              pause_len;
    logic [63:0]     ch;
    logic [2:0]      xst;
    int              xfin;
    int              xprog;
  } vec_t;
  typedef struct {
    logic [2:0]  st;
    logic [31:0] fc;
    logic [63:0] sn;
  } exp_t;
  vec_t vt[7];
  exp_t q[$];
  int checks = 0, errors = 0, fin_seen = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (fin === 1'b1) begin
      fin_seen++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL finish with empty scoreboard: state %0d", st);
      end else begin
        e = q.pop_front();
        chk("terminal state", st, e.st);
        chk("final count", fc, e.fc);
        chk("terminal snap", snap, e.sn);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check_zero(input string n);
    chk({n, " state"}, st, 0);
    chk({n, " count"}, cc, 0);
    chk({n, " final"}, fc, 0);
    chk({n, " snap"}, snap, 0);
    chk({n, " finish"}, fin, 0);
    chk({n, " progress"}, prog, 0);
  endtask
  task automatic run_vec(input vec_t v);
    int k, np;
    logic [31:0] m;
    logic [63:0] xs;
    bit e, xp;
    q.push_back('{v.xst, 32'(v.xfin), v.ch});
    fin_seen = 0;
    chan = v.ch;
    en = 1'b1;
    dw = DV;
    tick();
    chk("idle to run", st, 1);
    chk("start count", cc, 0);
    m = 0; xs = 0; np = 0; k = 0;
    while (st == 3'd1 && k < 300) begin
      e  = !(k >= v.pause_at && k < v.pause_at + v.pause_len);
      en = e;
      dw = (k >= v.pat_at && k < v.pat_at + v.pat_len) ? v.pat[k - v.pat_at] : 32'h2;
      tick();
      if (st == 3'd1) begin
        if (e) m = m + 1;
        chk("live count", cc, m);
`ifdef RUN_MONITOR_PROGRESS_EN
        xp = e && m != 0 && m[3:0] == 4'h0;
`else
        xp = 1'b0;
`endif
        chk("progress pulse", prog, xp);
        if (xp) begin
          xs = v.ch;
          np++;
        end
        chk("snap during run", snap, xs);
      end
      k++;
    end
    if (k >= 300) begin
      checks++;
      errors++;
      $display("FAIL run bound: no terminal state after %0d edges, state %0d", k, st);
    end
`ifdef RUN_MONITOR_PROGRESS_EN
    chk("progress pulse total", np, v.xprog);
`else
    chk("progress pulse total", np, 0);
`endif
    en = 1'b1;
    dw = FV;
    repeat (3) begin
      tick();
      chk("hold finish low", fin, 0);
      chk("hold state", st, v.xst);
      chk("hold final", fc, v.xfin);
      chk("hold count", cc, m);
      chk("hold snap", snap, v.ch);
    end
    chk("finish pulse total", fin_seen, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("reset after terminal");
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    vt[0] = '{20, 3, {32'h0, 32'h0, 32'h0, DV, DV, DV}, 0, 0, {32'h5, 32'hA}, 3'd2, 22, 1};
    vt[1] = '{30, 6, {DV, DV, DV, 32'h0, DV, DV}, 0, 0, {32'h1234, 32'h5678}, 3'd2, 35, 2};
    vt[2] = '{0, 0, '0, 0, 0, {32'hCAFE, 32'hF00D}, 3'd4, 100, 6};
    vt[3] = '{98, 3, {32'h0, 32'h0, 32'h0, FV, DV, DV}, 0, 0, {32'h77, 32'h88}, 3'd3, 100, 6};
    vt[4] = '{0, 0, '0, 50, 10, {32'h1, 32'h2}, 3'd4, 100, 6};
    vt[5] = '{5, 1, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, FV}, 0, 0, {32'hDEAD, 32'hBEEF}, 3'd3, 5, 0};
    vt[6] = '{52, 3, {32'h0, 32'h0, 32'h0, DV, DV, DV}, 50, 10, {32'h99, 32'h66}, 3'd2, 50, 3};
    rst = 1'b1; en = 1'b0; dw = 32'h0; chan = 64'h0;
    repeat (2) tick();
    check_zero("power-on reset");
    rst = 1'b0;
    dw = FV;
    tick();
    chk("idle ignores codes", st, 0);
    for (int i = 0; i < 7; i++) run_vec(vt[i]);
    en = 1'b1; dw = 32'h2; chan = 64'hFF;
    repeat (31) tick();
    chk("mid-run count", cc, 30);
    rst = 1'b1; dw = FV;
    tick();
    rst = 1'b0;
    check_zero("reset mid-run");
    dw = 32'h2;
    tick();
    chk("restart state", st, 1);
    chk("restart count", cc, 0);
    tick();
    chk("restart count step", cc, 1);
    chk("scoreboard drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
